fetch_queue_stage: RTL and testbench

- Parametrised instruction-fetch stage; successor to the single-register fetch stage.
- Issues reads to instruction memory through a readM/ready handshake that tolerates variable latency.
- Buffers fetched words in a DEPTH-entry FIFO in front of decode.
- Supports decode back-pressure and branch/jump redirect, including redirect while a read is in flight.

---
 rtl/fetch_queue_stage_pkg.sv | 13 +
 rtl/fetch_queue_stage_inst_fifo.sv | 72 +++++++
 rtl/fetch_queue_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_queue_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_stage_pkg.sv
// Shared definitions for the queued fetch stage and its instruction FIFO.
package fetch_queue_stage_pkg;

  localparam int WORD_SIZE_DEFAULT = 16;
  localparam int DEPTH_DEFAULT     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetchState_e;

endpackage

// File: rtl/fetch_queue_stage_inst_fifo.sv
// Power-of-two circular FIFO with synchronous reset, flush, push/pop and count;
// the head word is shown combinationally and reads as zero when empty.
module inst_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         pushData_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         popData_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign popData_o = empty_o ? '0 : entries_q[rdPtr_q];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !flush_i && doPush) entries_q[wrPtr_q] <= pushData_i;
  end

  always @(posedge clk) begin
    if (reset_n && !flush_i && push_i && full_o) assert (pop_i);
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: variable-latency readM/mem_ready memory interface feeding
// a DEPTH-entry instruction queue, with decode back-pressure and branch redirect.
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter int                   WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int                   DEPTH     = DEPTH_DEFAULT,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   redirect_valid,
  input  logic [WORD_SIZE-1:0]   redirect_target,
  output logic                   readM,
  output logic [WORD_SIZE-1:0]   address,
  inout  wire  [WORD_SIZE-1:0]   data,
  input  logic                   mem_ready,
  input  logic                   id_ready,
  output logic                   inst_valid,
  output logic [WORD_SIZE-1:0]   inst,
  output logic [WORD_SIZE-1:0]   inst_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetchState_e            state_q, state_d;
  logic                   readM_q, readM_d;
  logic [WORD_SIZE-1:0]   address_q, address_d;
  logic [WORD_SIZE-1:0]   fetchPc_q, fetchPc_d;
  logic [WORD_SIZE-1:0]   addrNext;
  logic [CNT_W-1:0]       count, occAfter;
  logic                   full, empty;
  logic                   pushEn, popEn;
  logic [2*WORD_SIZE-1:0] headData;

  assign data = {WORD_SIZE{1'bz}};

  // A redirect voids both the returning word and decode's pop in that cycle.
  assign addrNext = address_q + WORD_SIZE'(1);
  assign pushEn   = (state_q == WAIT) && mem_ready && !redirect_valid;
  assign popEn    = !empty && id_ready && !redirect_valid;
  assign occAfter = count + CNT_W'(pushEn) - CNT_W'(popEn);

  inst_fifo #(
    .WIDTH (2 * WORD_SIZE),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (redirect_valid),
    .push_i     (pushEn),
    .pushData_i ({data, addrNext}),
    .pop_i      (popEn),
    .popData_o  (headData),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count)
  );

  always_comb begin
    state_d   = state_q;
    readM_d   = readM_q;
    address_d = address_q;
    fetchPc_d = fetchPc_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetchPc_d = redirect_target;
          readM_d   = 1'b1;
          address_d = redirect_target;
          state_d   = WAIT;
        end else if (count < CNT_W'(DEPTH)) begin
          readM_d   = 1'b1;
          address_d = fetchPc_q;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          fetchPc_d = redirect_target;
          if (mem_ready) begin
            address_d = redirect_target;
          end else begin
            state_d = DISCARD;
          end
        end else if (mem_ready) begin
          fetchPc_d = addrNext;
          if (occAfter < CNT_W'(DEPTH)) begin
            address_d = addrNext;
          end else begin
            readM_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        // The stale request must complete before the new target can be issued.
        if (redirect_valid) begin
          fetchPc_d = redirect_target;
          if (mem_ready) begin
            address_d = redirect_target;
            state_d   = WAIT;
          end
        end else if (mem_ready) begin
          if (count < CNT_W'(DEPTH)) begin
            address_d = fetchPc_q;
            state_d   = WAIT;
          end else begin
            readM_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        readM_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      readM_q   <= 1'b0;
      address_q <= '0;
      fetchPc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      readM_q   <= readM_d;
      address_q <= address_d;
      fetchPc_q <= fetchPc_d;
    end
  end

  assign readM      = readM_q;
  assign address    = address_q;
  assign inst_valid = !empty;
  assign inst       = headData[2*WORD_SIZE-1:WORD_SIZE];
  assign inst_pc    = headData[WORD_SIZE-1:0];
  assign occupancy  = count;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage; memory returns address ^ C0DE on the data bus.
module tb_fetch_queue_stage;

  typedef struct {
    logic        rstN;
    logic        redir;
    logic [15:0] target;
    logic        memRdy;
    logic        idRdy;
    logic        eReadM;
    logic [15:0] eAddr;
    logic        eValid;
    logic [15:0] eInst;
    logic [15:0] ePc;
    logic [2:0]  eOcc;
  } vec_t;

  logic        clk;
  logic        resetN;
  logic        redirValid;
  logic [15:0] redirTarget;
  logic        memReady;
  logic        idReady;
  logic        readM;
  logic [15:0] address;
  wire  [15:0] dataBus;
  logic        instValid;
  logic [15:0] inst;
  logic [15:0] instPc;
  logic [2:0]  occupancy;

  int checkCount;
  int errorCount;
  vec_t vecs[$];

  assign dataBus = address ^ 16'hC0DE;

  fetch_queue_stage #(
    .WORD_SIZE (16),
    .DEPTH     (4),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk             (clk),
    .reset_n         (resetN),
    .redirect_valid  (redirValid),
    .redirect_target (redirTarget),
    .readM           (readM),
    .address         (address),
    .data            (dataBus),
    .mem_ready       (memReady),
    .id_ready        (idReady),
    .inst_valid      (instValid),
    .inst            (inst),
    .inst_pc         (instPc),
    .occupancy       (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic rstN, input logic redir, input logic [15:0] target,
                        input logic memRdy, input logic idRdy, input logic eReadM,
                        input logic [15:0] eAddr, input logic eValid, input logic [15:0] eInst,
                        input logic [15:0] ePc, input logic [2:0] eOcc);
    vec_t v;
    v.rstN = rstN; v.redir = redir; v.target = target; v.memRdy = memRdy; v.idRdy = idRdy;
    v.eReadM = eReadM; v.eAddr = eAddr; v.eValid = eValid; v.eInst = eInst;
    v.ePc = ePc; v.eOcc = eOcc;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    resetN      = v.rstN;
    redirValid  = v.redir;
    redirTarget = v.target;
    memReady    = v.memRdy;
    idReady     = v.idRdy;
  endtask

  task automatic checkOutput(input string name, input logic eReadM, input logic [15:0] eAddr,
                             input logic eValid, input logic [15:0] eInst,
                             input logic [15:0] ePc, input logic [2:0] eOcc);
    checkCount++;
    if (readM !== eReadM || address !== eAddr || instValid !== eValid ||
        inst !== eInst || instPc !== ePc || occupancy !== eOcc) begin
      errorCount++;
      $display("[TB] FAIL %s: got readM=%0b addr=%h valid=%0b inst=%h pc=%h occ=%0d, want readM=%0b addr=%h valid=%0b inst=%h pc=%h occ=%0d",
               name, readM, address, instValid, inst, instPc, occupancy,
               eReadM, eAddr, eValid, eInst, ePc, eOcc);
    end
  endtask

  task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    resetN     = 1'b0;
    redirValid = 1'b0;
    redirTarget = 16'h0000;
    memReady   = 1'b0;
    idReady    = 1'b0;
    step();
    step();
    resetN = 1'b1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;

    // Zero-wait fetch, reset with a response pending, fill to DEPTH, drain,
    // redirect into DISCARD, then redirect coinciding with mem_ready.
    addVec(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 16'h0000, 1, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 16'h0000, 1, 1, 1, 16'h0001, 1, 16'hC0DE, 16'h0001, 1);
    addVec(1, 0, 16'h0000, 1, 1, 1, 16'h0002, 1, 16'hC0DF, 16'h0002, 1);
    addVec(0, 0, 16'h0000, 1, 1, 1, 16'h0003, 1, 16'hC0DC, 16'h0003, 1);
    addVec(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 16'h0000, 1, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 16'h0000, 1, 0, 1, 16'h0001, 1, 16'hC0DE, 16'h0001, 1);
    addVec(1, 0, 16'h0000, 1, 0, 1, 16'h0002, 1, 16'hC0DE, 16'h0001, 2);
    addVec(1, 0, 16'h0000, 1, 0, 1, 16'h0003, 1, 16'hC0DE, 16'h0001, 3);
    addVec(1, 0, 16'h0000, 0, 0, 0, 16'h0003, 1, 16'hC0DE, 16'h0001, 4);
    addVec(1, 0, 16'h0000, 0, 0, 0, 16'h0003, 1, 16'hC0DE, 16'h0001, 4);
    addVec(1, 0, 16'h0000, 0, 1, 0, 16'h0003, 1, 16'hC0DE, 16'h0001, 4);
    addVec(1, 0, 16'h0000, 0, 1, 0, 16'h0003, 1, 16'hC0DF, 16'h0002, 3);
    addVec(1, 0, 16'h0000, 1, 1, 1, 16'h0004, 1, 16'hC0DC, 16'h0003, 2);
    addVec(1, 0, 16'h0000, 0, 1, 1, 16'h0005, 1, 16'hC0DD, 16'h0004, 2);
    addVec(1, 0, 16'h0000, 0, 1, 1, 16'h0005, 1, 16'hC0DA, 16'h0005, 1);
    addVec(1, 1, 16'h0040, 0, 1, 1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 16'h0000, 0, 1, 1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 16'h0000, 1, 1, 1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 16'h0000, 0, 1, 1, 16'h0040, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 16'h0000, 1, 1, 1, 16'h0040, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 1, 16'h0100, 1, 1, 1, 16'h0041, 1, 16'hC09E, 16'h0041, 1);
    addVec(1, 0, 16'h0000, 1, 0, 1, 16'h0100, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 16'h0000, 0, 0, 1, 16'h0101, 1, 16'hC1DE, 16'h0101, 1);

    doReset();
    resetN = 1'b0;
    step();
    step();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].eReadM, vecs[i].eAddr, vecs[i].eValid,
                  vecs[i].eInst, vecs[i].ePc, vecs[i].eOcc);
      step();
    end

    // Three-cycle memory latency: request must hold steady until mem_ready.
    doReset();
    step();
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 3; k++) begin
        checkField($sformatf("lat_readM_w%0d_k%0d", w, k), {15'd0, readM}, 16'h0001);
        checkField($sformatf("lat_addr_w%0d_k%0d", w, k), address, 16'(w));
        memReady = (k == 2);
        step();
      end
    end
    memReady = 1'b0;
    checkOutput("lat_queued", 1'b1, 16'h0002, 1'b1, 16'hC0DE, 16'h0001, 3'd2);
    idReady = 1'b1;
    step();
    checkOutput("lat_second", 1'b1, 16'h0002, 1'b1, 16'hC0DF, 16'h0002, 3'd1);
    step();
    checkOutput("lat_drained", 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000, 3'd0);

    // Redirect with a full queue and a simultaneous pop handshake.
    doReset();
    memReady = 1'b1;
    for (int n = 0; n < 5; n++) step();
    checkOutput("full_before", 1'b0, 16'h0003, 1'b1, 16'hC0DE, 16'h0001, 3'd4);
    redirValid  = 1'b1;
    redirTarget = 16'h0080;
    idReady     = 1'b1;
    memReady    = 1'b0;
    step();
    redirValid = 1'b0;
    checkOutput("full_flushed", 1'b1, 16'h0080, 1'b0, 16'h0000, 16'h0000, 3'd0);
    memReady = 1'b1;
    idReady  = 1'b0;
    step();
    checkOutput("full_first_new", 1'b1, 16'h0081, 1'b1, 16'hC05E, 16'h0081, 3'd1);

    // Redirect from IDLE to FFFF: the following PC wraps to 0000.
    doReset();
    redirValid  = 1'b1;
    redirTarget = 16'hFFFF;
    idReady     = 1'b1;
    step();
    redirValid = 1'b0;
    checkOutput("wrap_issue", 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 3'd0);
    memReady = 1'b1;
    step();
    checkOutput("wrap_ffff", 1'b1, 16'h0000, 1'b1, 16'h3F21, 16'h0000, 3'd1);
    step();
    checkOutput("wrap_0000", 1'b1, 16'h0001, 1'b1, 16'hC0DE, 16'h0001, 3'd1);

    // Reset mid-WAIT at 0010 with the response arriving on the reset edge.
    doReset();
    redirValid  = 1'b1;
    redirTarget = 16'h0010;
    step();
    redirValid = 1'b0;
    checkOutput("rst_wait", 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0000, 3'd0);
    resetN   = 1'b0;
    memReady = 1'b1;
    step();
    checkOutput("rst_applied", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0);
    resetN   = 1'b1;
    memReady = 1'b0;
    step();
    checkOutput("rst_restart", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
